oled_cmd_ctrl: RTL and testbench

- Command interpreter and write-address sequencer for the 128x64 OLED framebuffer (1024 bytes, 8 pages x 128 columns, byte = 8 vertical pixels, LSB on top).
- Consumes the byte stream captured from the console's OLED bus, decodes SSD1306-style command bytes, and generates framebuffer write strobes and addresses for data bytes.
- Exports display configuration (on/off, invert, contrast) to the scan-out path and replaces the fixed linear write counter.

---
 rtl/oled_cmd_if.sv | 24 ++
 rtl/oled_cmd_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_oled_cmd_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/oled_cmd_if.sv
// Bus bundle for the OLED command controller: captured byte stream in,
// framebuffer write port and display configuration out.
interface oled_cmd_if;
  logic       byte_valid;
  logic       oled_dc;
  logic [7:0] oled_data;
  logic       fb_we;
  logic [9:0] fb_waddr;
  logic [7:0] fb_wdata;
  logic       frame_done;
  logic       display_on;
  logic       invert;
  logic [7:0] contrast;

  modport master (
    output byte_valid, oled_dc, oled_data,
    input  fb_we, fb_waddr, fb_wdata, frame_done, display_on, invert, contrast
  );

  modport slave (
    input  byte_valid, oled_dc, oled_data,
    output fb_we, fb_waddr, fb_wdata, frame_done, display_on, invert, contrast
  );
endinterface

// File: rtl/oled_cmd_ctrl.sv
// SSD1306-style command interpreter and framebuffer write-address sequencer
// for a 128x64 OLED (8 pages x 128 columns, one byte per page column).
module oled_cmd_ctrl #(
  parameter int COLS  = 128,
  parameter int PAGES = 8
) (
  input  logic       clock,
  input  logic       reset,
  oled_cmd_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARG1 = 2'd1;
  localparam logic [1:0] S_ARG2 = 2'd2;

  logic [1:0] state_q,      state_d;
  logic [7:0] op_q,         op_d;
  logic [6:0] arg_q,        arg_d;
  logic [1:0] mode_q,       mode_d;
  logic [6:0] col_start_q,  col_start_d;
  logic [6:0] col_end_q,    col_end_d;
  logic [2:0] page_start_q, page_start_d;
  logic [2:0] page_end_q,   page_end_d;
  logic [6:0] col_q,        col_d;
  logic [2:0] page_q,       page_d;
  logic       fb_we_q,      fb_we_d;
  logic [9:0] fb_waddr_q,   fb_waddr_d;
  logic [7:0] fb_wdata_q,   fb_wdata_d;
  logic       frame_done_q, frame_done_d;
  logic       display_on_q, display_on_d;
  logic       invert_q,     invert_d;
  logic [7:0] contrast_q,   contrast_d;

  // Column step: wraps only on equality with the end, so start > end windows
  // run through the modulo-128 rollover.
  function automatic logic [6:0] next_col(input logic [6:0] c,
                                          input logic [6:0] c_start,
                                          input logic [6:0] c_end);
    logic [6:0] r;
    if (c == c_end) begin
      r = c_start;
    end else begin
      r = c + 7'd1;
    end
    return r;
  endfunction

  function automatic logic [2:0] next_page(input logic [2:0] p,
                                           input logic [2:0] p_start,
                                           input logic [2:0] p_end);
    logic [2:0] r;
    if (p == p_end) begin
      r = p_start;
    end else begin
      r = p + 3'd1;
    end
    return r;
  endfunction

  // Next-state: data writes with pointer advance, command decode, argument capture.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    arg_d        = arg_q;
    mode_d       = mode_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    col_d        = col_q;
    page_d       = page_q;
    fb_we_d      = 1'b0;
    fb_waddr_d   = fb_waddr_q;
    fb_wdata_d   = fb_wdata_q;
    frame_done_d = 1'b0;
    display_on_d = display_on_q;
    invert_d     = invert_q;
    contrast_d   = contrast_q;

    if (bus.byte_valid && bus.oled_dc) begin
      // A data byte drops any half-received command without applying it.
      state_d    = S_IDLE;
      fb_we_d    = 1'b1;
      fb_waddr_d = {page_q, col_q};
      fb_wdata_d = bus.oled_data;
      case (mode_q)
        2'd0: begin
          col_d = next_col(col_q, col_start_q, col_end_q);
          if (col_q == col_end_q) begin
            page_d       = next_page(page_q, page_start_q, page_end_q);
            frame_done_d = (page_q == page_end_q);
          end else begin
            page_d = page_q;
          end
        end
        2'd1: begin
          page_d = next_page(page_q, page_start_q, page_end_q);
          if (page_q == page_end_q) begin
            col_d = next_col(col_q, col_start_q, col_end_q);
          end else begin
            col_d = col_q;
          end
        end
        default: begin
          col_d = next_col(col_q, col_start_q, col_end_q);
        end
      endcase
    end else if (bus.byte_valid) begin
      case (state_q)
        S_IDLE: begin
          casez (bus.oled_data)
            8'b0000_????: col_d        = {col_q[6:4], bus.oled_data[3:0]};
            8'b0001_????: col_d        = {bus.oled_data[2:0], col_q[3:0]};
            8'b1011_0???: page_d       = bus.oled_data[2:0];
            8'hA6:        invert_d     = 1'b0;
            8'hA7:        invert_d     = 1'b1;
            8'hAE:        display_on_d = 1'b0;
            8'hAF:        display_on_d = 1'b1;
            8'h20, 8'h21, 8'h22, 8'h81, 8'hA8, 8'hD3,
            8'hD5, 8'hD8, 8'hD9, 8'hDA, 8'hDB, 8'h8D: begin
              op_d    = bus.oled_data;
              state_d = S_ARG1;
            end
            default: state_d = S_IDLE;
          endcase
        end
        S_ARG1: begin
          case (op_q)
            8'h20: begin
              mode_d  = (bus.oled_data[1:0] == 2'd3) ? 2'd2 : bus.oled_data[1:0];
              state_d = S_IDLE;
            end
            8'h81: begin
              contrast_d = bus.oled_data;
              state_d    = S_IDLE;
            end
            8'h21, 8'h22: begin
              arg_d   = bus.oled_data[6:0];
              state_d = S_ARG2;
            end
            default: state_d = S_IDLE;
          endcase
        end
        S_ARG2: begin
          state_d = S_IDLE;
          case (op_q)
            8'h21: begin
              col_start_d = arg_q;
              col_end_d   = bus.oled_data[6:0];
              col_d       = arg_q;
            end
            8'h22: begin
              page_start_d = arg_q[2:0];
              page_end_d   = bus.oled_data[2:0];
              page_d       = arg_q[2:0];
            end
            default: state_d = S_IDLE;
          endcase
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= 8'h00;
      arg_q        <= 7'd0;
      mode_q       <= 2'd2;
      col_start_q  <= 7'd0;
      col_end_q    <= 7'(COLS - 1);
      page_start_q <= 3'd0;
      page_end_q   <= 3'(PAGES - 1);
      col_q        <= 7'd0;
      page_q       <= 3'd0;
      fb_we_q      <= 1'b0;
      fb_waddr_q   <= 10'd0;
      fb_wdata_q   <= 8'h00;
      frame_done_q <= 1'b0;
      display_on_q <= 1'b0;
      invert_q     <= 1'b0;
      contrast_q   <= 8'h7F;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      arg_q        <= arg_d;
      mode_q       <= mode_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      col_q        <= col_d;
      page_q       <= page_d;
      fb_we_q      <= fb_we_d;
      fb_waddr_q   <= fb_waddr_d;
      fb_wdata_q   <= fb_wdata_d;
      frame_done_q <= frame_done_d;
      display_on_q <= display_on_d;
      invert_q     <= invert_d;
      contrast_q   <= contrast_d;
    end
  end

  assign bus.fb_we      = fb_we_q;
  assign bus.fb_waddr   = fb_waddr_q;
  assign bus.fb_wdata   = fb_wdata_q;
  assign bus.frame_done = frame_done_q;
  assign bus.display_on = display_on_q;
  assign bus.invert     = invert_q;
  assign bus.contrast   = contrast_q;

endmodule

// File: tb/tb_oled_cmd_ctrl.sv
// Bench for oled_cmd_ctrl: directed scenarios plus random byte streams
// checked against a pointer/command model kept in plain integers.
module tb_oled_cmd_ctrl;

  logic clock = 1'b0;
  logic reset;
  oled_cmd_if bus ();

  oled_cmd_ctrl #(.COLS(128), .PAGES(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: window, pointer, config and a pending-command list.
  int m_mode, m_cs, m_ce, m_ps, m_pe, m_col, m_page;
  int m_disp, m_inv, m_con;
  int m_op, m_need;
  int m_args[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = 2; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_col = 0; m_page = 0; m_disp = 0; m_inv = 0; m_con = 'h7F;
    m_need = 0; m_op = 0; m_args.delete();
  endfunction

  function automatic int col_step(input int c);
    return (c == m_ce) ? m_cs : (c + 1) % 128;
  endfunction

  function automatic int page_step(input int p);
    return (p == m_pe) ? m_ps : (p + 1) % 8;
  endfunction

  function automatic void model_apply();
    case (m_op)
      'h20: m_mode = ((m_args[0] % 4) == 3) ? 2 : (m_args[0] % 4);
      'h81: m_con = m_args[0];
      'h21: begin m_cs = m_args[0] % 128; m_ce = m_args[1] % 128; m_col = m_cs; end
      'h22: begin m_ps = m_args[0] % 8; m_pe = m_args[1] % 8; m_page = m_ps; end
      default: ;
    endcase
  endfunction

  // Presents one byte for one cycle (left asserted; back-to-back calls stream).
  task automatic send_byte(input bit dc, input int d);
    int exp_we, exp_addr, exp_fd;
    exp_we = 0; exp_fd = 0; exp_addr = 0;
    if (dc) begin
      m_need = 0;
      exp_we = 1;
      exp_addr = m_page * 128 + m_col;
      if (m_mode == 0) begin
        if (m_col == m_ce) begin
          exp_fd = (m_page == m_pe);
          m_page = page_step(m_page);
        end
        m_col = col_step(m_col);
      end else if (m_mode == 1) begin
        if (m_page == m_pe) m_col = col_step(m_col);
        m_page = page_step(m_page);
      end else begin
        m_col = col_step(m_col);
      end
    end else if (m_need > 0) begin
      m_args.push_back(d);
      if (m_args.size() == m_need) begin
        model_apply();
        m_need = 0;
      end
    end else begin
      if (d < 'h10) m_col = (m_col / 16) * 16 + (d % 16);
      else if (d < 'h20 && d >= 'h10) m_col = (d % 8) * 16 + (m_col % 16);
      else if (d >= 'hB0 && d <= 'hB7) m_page = d - 'hB0;
      else if (d == 'hA6) m_inv = 0;
      else if (d == 'hA7) m_inv = 1;
      else if (d == 'hAE) m_disp = 0;
      else if (d == 'hAF) m_disp = 1;
      if (d == 'h21 || d == 'h22) begin
        m_op = d; m_need = 2; m_args.delete();
      end else if (d == 'h20 || d == 'h81 || d == 'hA8 || d == 'hD3 || d == 'hD5 ||
                   d == 'hD8 || d == 'hD9 || d == 'hDA || d == 'hDB || d == 'h8D) begin
        m_op = d; m_need = 1; m_args.delete();
      end
    end
    bus.byte_valid = 1'b1;
    bus.oled_dc    = dc;
    bus.oled_data  = d[7:0];
    @(negedge clock);
    check_val("fb_we", bus.fb_we, exp_we);
    check_val("frame_done", bus.frame_done, exp_fd);
    if (exp_we != 0) begin
      check_val("fb_waddr", bus.fb_waddr, exp_addr);
      check_val("fb_wdata", bus.fb_wdata, d % 256);
    end
    check_val("display_on", bus.display_on, m_disp);
    check_val("invert", bus.invert, m_inv);
    check_val("contrast", bus.contrast, m_con);
  endtask

  task automatic idle();
    bus.byte_valid = 1'b0;
    @(negedge clock);
    check_val("idle_we", bus.fb_we, 0);
    check_val("idle_fd", bus.frame_done, 0);
  endtask

  task automatic do_reset();
    bus.byte_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    check_val("rst_we", bus.fb_we, 0);
    check_val("rst_waddr", bus.fb_waddr, 0);
    check_val("rst_wdata", bus.fb_wdata, 0);
    check_val("rst_fd", bus.frame_done, 0);
    check_val("rst_disp", bus.display_on, 0);
    check_val("rst_inv", bus.invert, 0);
    check_val("rst_con", bus.contrast, 'h7F);
  endtask

  task automatic send_cmds(input int c[]);
    foreach (c[i]) send_byte(1'b0, c[i]);
  endtask

  int cmd_tab[] = '{'h20, 'h21, 'h22, 'h81, 'hA6, 'hA7, 'hAE, 'hAF, 'hB0, 'hB5,
                    'hB7, 'h03, 'h0F, 'h12, 'h17, 'hA8, 'hD3, 'h8D, 'h7F, 'hE3};
  int win_exp[] = '{'h37E, 'h37F, 'h300, 'h301, 'h3FE, 'h3FF, 'h380, 'h381};

  initial begin
    int fd_cnt, r;
    reset = 1'b1;
    bus.byte_valid = 1'b0;
    bus.oled_dc = 1'b0;
    bus.oled_data = 8'h00;
    @(negedge clock);
    do_reset();

    // Full horizontal frame.
    send_cmds('{'h20, 'h00, 'h21, 'h00, 'h7F, 'h22, 'h00, 'h07});
    fd_cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      send_byte(1'b1, i % 256);
      check_val("frame_addr", bus.fb_waddr, i);
      if (bus.frame_done === 1'b1) begin
        fd_cnt++;
        check_val("frame_done_addr", bus.fb_waddr, 1023);
      end
    end
    check_val("frame_done_count", fd_cnt, 1);
    send_byte(1'b1, 'hAA);
    check_val("frame_wrap_addr", bus.fb_waddr, 0);
    idle();

    // Page-mode addressing from reset defaults.
    do_reset();
    send_cmds('{'hB3, 'h05, 'h14});
    for (int i = 0; i < 3; i++) begin
      send_byte(1'b1, 'h10 + i);
      check_val("page_addr", bus.fb_waddr, 'h1C5 + i);
    end
    idle();

    // Wrapping window with start > end columns.
    send_cmds('{'h20, 'h00, 'h21, 'h7E, 'h01, 'h22, 'h06, 'h07});
    for (int i = 0; i < 8; i++) begin
      send_byte(1'b1, 'hC0 + i);
      check_val("win_addr", bus.fb_waddr, win_exp[i]);
      check_val("win_fd", bus.frame_done, (i == 7) ? 1 : 0);
    end
    idle();

    // Vertical mode.
    send_cmds('{'h20, 'h01, 'h21, 'h00, 'h7F, 'h22, 'h00, 'h07});
    for (int i = 0; i < 9; i++) begin
      send_byte(1'b1, i);
      check_val("vert_addr", bus.fb_waddr, (i < 8) ? i * 128 : 1);
    end
    idle();

    // Display configuration and an aborted contrast command.
    send_cmds('{'hAF, 'hA7, 'h81, 'h3C});
    check_val("cfg_disp", bus.display_on, 1);
    check_val("cfg_inv", bus.invert, 1);
    check_val("cfg_con", bus.contrast, 'h3C);
    send_byte(1'b0, 'h81);
    send_byte(1'b1, 'h55);
    check_val("abort_con", bus.contrast, 'h3C);
    check_val("abort_wdata", bus.fb_wdata, 'h55);
    idle();

    // Reset in the middle of a two-argument command.
    do_reset();
    send_byte(1'b0, 'h21);
    do_reset();
    send_byte(1'b1, 'h99);
    check_val("midrst_addr", bus.fb_waddr, 0);
    send_byte(1'b0, 'h7F);
    send_byte(1'b1, 'h9A);
    check_val("midrst_next", bus.fb_waddr, 1);
    idle();

    // Random command/data mix against the model.
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0) do_reset();
      else if (r < 8) idle();
      else if (r < 110) send_byte(1'b1, $urandom_range(0, 255));
      else if (r < 170) send_byte(1'b0, cmd_tab[$urandom_range(0, cmd_tab.size() - 1)]);
      else send_byte(1'b0, $urandom_range(0, 255));
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
